// File: rtl/gpca_pipe.sv
// gpca_pipe: N-row cellular array (multiply/divide mode per transaction), one register stage per row, global stall
module gpca_pipe #(
  parameter int N = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           x,
  input  logic [N-1:0]   p,
  input  logic [N+1:0]   b,
  input  logic [N+1:0]   c,
  input  logic [2*N-1:0] a,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N:0]   s,
  output logic [N-1:0]   q,
  output logic           busy
);
  localparam int W = 2 * N + 1;
  typedef struct packed {
    logic         co;
    logic [W-1:0] s;
    logic [W-1:0] d;
    logic [W-1:0] e;
  } row_t;
  // One array row; vectors are LSB-first, so bit 0 is the last (LSB) cell and bit w-1 the MSB cell.
  function automatic row_t row_f(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic [W-1:0] cv, input logic xv, input logic pv,
                                 input int w);
    row_t     r;
    logic [W:0] cy;
    logic     bx;
    logic     f;
    r = '0;
    cy = '0;
    cy[0] = xv;
    for (int j = 0; j < W; j++) begin
      bx = bv[j] ^ xv;
      cy[j+1] = (j < w) && ((av[j] & bx) | (av[j] & cy[j]) | (bx & cy[j]));
    end
    r.co = cy[w];
    f = xv ? r.co : pv;
    for (int j = 0; j < W; j++) begin
      if (j < w) begin
        r.s[j] = f ? (av[j] ^ bv[j] ^ xv ^ cy[j]) : av[j];
        r.d[j] = cv[j] & (bv[j] | f);
        r.e[j] = bv[j] | (cv[j] & f);
      end
    end
    return r;
  endfunction
  logic [N-1:0]            v_q, v_d, x_q, x_d;
  logic [N-1:0][W-1:0]     s_q, s_d, d_q, d_d, e_q, e_d;
  logic [N-1:0][N-1:0]     q_q, q_d, p_q, p_d;
  logic [N-1:0][2*N-1:0]   a_q, a_d;
  logic [N-1:0][N+1:0]     b_q, b_d, c_q, c_d;
  row_t                    rw [N];
  for (genvar g = 0; g < N; g++) begin : g_row
    if (g == 0) begin : g_first
      assign rw[g] = row_f({{(W-2){1'b0}}, a[2*N-1], a[2*N-2]},
                           {{(W-3){1'b0}}, b[N+1:N-1]},
                           {{(W-3){1'b0}}, c[N+1:N-1]},
                           x, p[N-1], 3);
    end else begin : g_rest
      assign rw[g] = row_f((s_q[g-1] << 2) | {{(W-2){1'b0}}, a_q[g-1][2*N-2*g-1], a_q[g-1][2*N-2*g-2]},
                           (d_q[g-1] << 1) | {{(W-1){1'b0}}, b_q[g-1][N-1-g]},
                           (e_q[g-1] << 1) | {{(W-1){1'b0}}, c_q[g-1][N-1-g]},
                           x_q[g-1], p_q[g-1][N-1-g], 2*g+3);
    end
  end
  // Next stage contents: row results plus the shifted-along transaction context.
  always_comb begin
    v_d = {v_q[N-2:0], in_valid};
    x_d = {x_q[N-2:0], x};
    a_d = {a_q[N-2:0], a};
    b_d = {b_q[N-2:0], b};
    c_d = {c_q[N-2:0], c};
    p_d = {p_q[N-2:0], p};
    q_d = {q_q[N-2:0], {N{1'b0}}};
    for (int i = 0; i < N; i++) begin
      s_d[i] = rw[i].s;
      d_d[i] = rw[i].d;
      e_d[i] = rw[i].e;
      q_d[i][N-1-i] = rw[i].co;
    end
  end
  // Pipeline registers: whole pipe advances together unless a result is blocked at the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      x_q <= '0;
      s_q <= '0;
      d_q <= '0;
      e_q <= '0;
      q_q <= '0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      p_q <= '0;
    end else if (in_ready) begin
      v_q <= v_d;
      x_q <= x_d;
      s_q <= s_d;
      d_q <= d_d;
      e_q <= e_d;
      q_q <= q_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      p_q <= p_d;
    end
  end
  assign out_valid = v_q[N-1];
  assign s         = s_q[N-1];
  assign q         = q_q[N-1];
  assign busy      = |v_q;
  assign in_ready  = !(out_valid && !out_ready);
endmodule

// File: tb/tb_gpca_pipe.sv
// tb_gpca_pipe: vector table, handshake corner cases and random scoreboard against a cell-level model
module tb_gpca_pipe;
  localparam int N = 5;
  localparam int W = 2 * N + 1;
  logic           clk = 0, rst_n = 0, in_valid = 0, x = 0, out_ready = 1;
  logic [N-1:0]   p = '0;
  logic [N+1:0]   b = '0, c = '0;
  logic [2*N-1:0] a = '0;
  logic           in_ready, out_valid, busy;
  logic [W-1:0]   s;
  logic [N-1:0]   q;
  gpca_pipe #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .p(p), .b(b), .c(c), .a(a), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .q(q), .busy(busy));
  always #5 clk = ~clk;
  typedef struct packed { logic [W-1:0] s; logic [N-1:0] q; } res_t;
  typedef struct { res_t r; int t; } exp_t;
  typedef struct {
    logic xx; logic [N-1:0] pp; logic [2*N-1:0] aa; logic [N+1:0] bb, cc;
    logic [W-1:0] es; logic [N-1:0] eq;
  } vec_t;
  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0, retired = 0;
  bit chk_lat = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  // Array evaluated cell by cell, 1-based with cell 1 = MSB, straight from the row feeding rules.
  function automatic res_t model(input logic xm, input logic [N-1:0] pm, input logic [2*N-1:0] am,
                                 input logic [N+1:0] bm, input logic [N+1:0] cm);
    int S[N+1][W+1], D[N+1][W+1], E[N+1][W+1];
    int A[W+1], B[W+1], C[W+1], co[W+1], ci[W+1];
    int w, cin, f, xi;
    res_t r;
    r = '0;
    xi = int'(xm);
    for (int i = 1; i <= N; i++) begin
      w = 2 * i + 1;
      for (int k = 1; k <= w; k++) begin
        if (i == 1) begin
          A[k] = (k == 1) ? 0 : int'(am[2*N-(k-1)]);
          B[k] = int'(bm[N+2-k]);
          C[k] = int'(cm[N+2-k]);
        end else if (k == 1) begin
          A[k] = S[i-1][1]; B[k] = 0; C[k] = 0;
        end else if (k <= 2 * i - 1) begin
          A[k] = S[i-1][k]; B[k] = D[i-1][k-1]; C[k] = E[i-1][k-1];
        end else if (k == 2 * i) begin
          A[k] = int'(am[2*N-(2*i-1)]); B[k] = D[i-1][2*i-1]; C[k] = E[i-1][2*i-1];
        end else begin
          A[k] = int'(am[2*N-2*i]); B[k] = int'(bm[N-i]); C[k] = int'(cm[N-i]);
        end
      end
      cin = xi;
      for (int k = w; k >= 1; k--) begin
        ci[k] = cin;
        co[k] = ((A[k] + (B[k] ^ xi) + cin) >= 2) ? 1 : 0;
        cin = co[k];
      end
      f = xm ? co[1] : int'(pm[N-i]);
      for (int k = 1; k <= w; k++) begin
        S[i][k] = (f != 0) ? ((A[k] + B[k] + xi + ci[k]) % 2) : A[k];
        D[i][k] = C[k] & (B[k] | f);
        E[i][k] = B[k] | (C[k] & f);
      end
      r.q[N-i] = co[1][0];
    end
    for (int k = 1; k <= W; k++) r.s[W-k] = S[N][k][0];
    return r;
  endfunction
  // Scoreboard: predict at acceptance, compare at retirement.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got s=%0h q=%0h with nothing outstanding", s, q);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_s", 64'(s), 64'(e.r.s));
          chk("sb_q", 64'(q), 64'(e.r.q));
          if (chk_lat) chk("sb_latency", 64'(cyc - e.t), 64'(N));
          retired++;
        end
      end
      if (in_valid && in_ready) sb.push_back('{model(x, p, a, b, c), cyc});
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rnd_in();
    p = N'($urandom);
    a = (2*N)'($urandom);
    b = (N+2)'($urandom);
    c = (N+2)'($urandom);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    vec_t tv[6];
    int n, r0, sent;
    logic [W-1:0] ss;
    logic [N-1:0] qq;
    logic xa, acc;
    tv[0] = '{1'b0, 5'b00000, 10'b1011001110, 7'd0, 7'd0, 11'b01011001110, 5'b00000};
    tv[1] = '{1'b0, 5'b11111, 10'b1011001110, 7'd0, 7'd0, 11'b01011001110, 5'b00000};
    tv[2] = '{1'b0, 5'b00000, 10'h3FF,        7'd0, 7'd0, 11'h3FF,        5'b00000};
    tv[3] = '{1'b0, 5'b10101, 10'h155,        7'd0, 7'd0, 11'h155,        5'b00000};
    tv[4] = '{1'b1, 5'b00000, 10'h000,        7'd0, 7'd0, 11'h000,        5'b11111};
    tv[5] = '{1'b1, 5'b01010, 10'h3FF,        7'd0, 7'd0, 11'h3FF,        5'b11111};
    repeat (2) tick();
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_s", 64'(s), 0);
    chk("rst_q", 64'(q), 0);
    @(negedge clk);
    rst_n = 1;
    chk_lat = 1;
    for (int i = 0; i < 6; i++) begin
      x = tv[i].xx; p = tv[i].pp; a = tv[i].aa; b = tv[i].bb; c = tv[i].cc;
      in_valid = 1;
      #1;
      chk("vec_in_ready", 64'(in_ready), 1);
      tick();
      in_valid = 0;
      n = 0;
      while (!out_valid && n < 20) begin
        tick();
        n++;
      end
      chk("vec_latency", 64'(n + 1), 64'(N));
      chk("vec_s", 64'(s), 64'(tv[i].es));
      chk("vec_q", 64'(q), 64'(tv[i].eq));
    end
    tick();
    r0 = retired;
    for (int i = 0; i < 5; i++) begin
      x = i[0];
      rnd_in();
      in_valid = 1;
      tick();
    end
    in_valid = 0;
    repeat (2 * N + 2) tick();
    chk("b2b_retired", 64'(retired - r0), 5);
    chk("b2b_idle_busy", 64'(busy), 0);
    chk_lat = 0;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      x = i[0];
      rnd_in();
      in_valid = 1;
      tick();
    end
    n = 0;
    while (!out_valid && n < 20) begin
      rnd_in();
      tick();
      n++;
    end
    chk("stall_out_valid", 64'(out_valid), 1);
    ss = s;
    qq = q;
    for (int i = 0; i < 3; i++) begin
      rnd_in();
      tick();
      chk("stall_s_stable", 64'(s), 64'(ss));
      chk("stall_q_stable", 64'(q), 64'(qq));
      chk("stall_in_ready", 64'(in_ready), 0);
      chk("stall_valid_held", 64'(out_valid), 1);
    end
    in_valid = 0;
    out_ready = 1;
    repeat (3 * N) tick();
    chk("stall_drain_empty", 64'(sb.size()), 0);
    chk("stall_busy", 64'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      rnd_in();
      in_valid = 1;
      tick();
    end
    in_valid = 0;
    tick();
    #2;
    rst_n = 0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 0);
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_in_ready", 64'(in_ready), 1);
    chk("midrst_s", 64'(s), 0);
    chk("midrst_q", 64'(q), 0);
    sb.delete();
    @(posedge clk);
    #3;
    rst_n = 1;
    for (int i = 0; i < 2 * N; i++) begin
      tick();
      chk("no_stale_output", 64'(out_valid), 0);
    end
    xa = 0;
    sent = 0;
    n = 0;
    while (sent < 10000 && n < 60000) begin
      in_valid = ($urandom_range(0, 4) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      x = xa;
      rnd_in();
      #1;
      acc = in_valid && in_ready;
      tick();
      n++;
      if (acc) begin
        sent++;
        xa = ~xa;
      end
    end
    chk("rand_all_sent", 64'(sent), 10000);
    in_valid = 0;
    out_ready = 1;
    repeat (3 * N) tick();
    chk("rand_drain_empty", 64'(sb.size()), 0);
    chk("rand_busy", 64'(busy), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
